// File: rtl/ciclo_lavagem.sv
// rtl/ciclo_lavagem.sv - wash-cycle sequencer: fill/wash/drain/rinse/spin with second-based timers
module ciclo_lavagem #(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int WASH_S         = 10,
    parameter int RINSE_S        = 5,
    parameter int SPIN_S         = 8,
    parameter int FILL_TIMEOUT_S = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       start,
    input  logic       pause,
    input  logic       door_closed,
    input  logic       water_full,
    input  logic       water_empty,
    output logic       valve_in,
    output logic       pump_out,
    output logic       motor_wash,
    output logic       motor_spin,
    output logic       door_lock,
    output logic [2:0] phase,
    output logic [7:0] secs_left,
    output logic       paused,
    output logic       done,
    output logic       error
);
    localparam int            PW          = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX     = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    WASH_STEP   = 8'(WASH_S);
    localparam logic [7:0]    RINSE_DUR   = 8'(RINSE_S);
    localparam logic [7:0]    SPIN_DUR    = 8'(SPIN_S);
    localparam logic [7:0]    TIMEOUT_DUR = 8'(FILL_TIMEOUT_S);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    state_t        state, n_state;
    logic [2:0]    mode_q, n_mode;
    logic [1:0]    rinses_left, n_rinses;
    logic          washed, n_washed;
    logic [PW-1:0] presc, n_presc;
    logic [7:0]    n_secs;
    logic          n_paused;
    logic          n_running;
    logic          tick;
    logic          last_sec;
    logic [7:0]    wash_dur;
    logic [7:0]    spin_dur;

    assign phase    = state;
    assign wash_dur = {5'd0, mode_q} * WASH_STEP;
    assign spin_dur = (mode_q == 3'd4) ? (SPIN_DUR + SPIN_DUR) : SPIN_DUR;

    // Next-state, timer and pause decisions; a frozen (paused) cycle neither ticks nor changes phase
    always_comb begin
        n_state  = state;
        n_mode   = mode_q;
        n_rinses = rinses_left;
        n_washed = washed;
        n_presc  = presc;
        n_secs   = secs_left;
        n_paused = paused;
        tick     = (presc == PRE_MAX);
        last_sec = tick && (secs_left == 8'd1);
        case (state)
            S_IDLE: begin
                if (start && door_closed && (mode >= 3'd1) && (mode <= 3'd4)) begin
                    n_state  = S_FILL;
                    n_mode   = mode;
                    n_rinses = (mode >= 3'd3) ? 2'd2 : 2'd1;
                    n_washed = 1'b0;
                end
            end
            S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
                if (paused) begin
                    if (pause && door_closed) n_paused = 1'b0;
                end else begin
                    if (tick) begin
                        n_presc = '0;
                        n_secs  = secs_left - 8'd1;
                    end else begin
                        n_presc = presc + 1'b1;
                    end
                    if (pause || !door_closed) n_paused = 1'b1;
                    case (state)
                        S_FILL: begin
                            // the level sensor beats a simultaneous timeout
                            if (water_full) begin
                                n_state  = washed ? S_RINSE : S_WASH;
                                n_washed = 1'b1;
                            end else if (last_sec) begin
                                n_state = S_ERROR;
                            end
                        end
                        S_DRAIN: begin
                            if (water_empty) begin
                                if (rinses_left != 2'd0) begin
                                    n_rinses = rinses_left - 2'd1;
                                    n_state  = S_FILL;
                                end else begin
                                    n_state = S_SPIN;
                                end
                            end else if (last_sec) begin
                                n_state = S_ERROR;
                            end
                        end
                        S_WASH, S_RINSE: if (last_sec) n_state = S_DRAIN;
                        S_SPIN:          if (last_sec) n_state = S_DONE;
                        default: ;
                    endcase
                end
            end
            S_DONE: if (!door_closed) n_state = S_IDLE;
            default: ;
        endcase
        n_running = n_state inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN};
        if (n_state != state) begin
            n_presc = '0;
            case (n_state)
                S_FILL, S_DRAIN: n_secs = TIMEOUT_DUR;
                S_WASH:          n_secs = wash_dur;
                S_RINSE:         n_secs = RINSE_DUR;
                S_SPIN:          n_secs = spin_dur;
                default:         n_secs = 8'd0;
            endcase
        end
        if (!n_running) n_paused = 1'b0;
    end

    // State register with actuator/status outputs registered from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            mode_q      <= 3'd0;
            rinses_left <= 2'd0;
            washed      <= 1'b0;
            presc       <= '0;
            secs_left   <= 8'd0;
            paused      <= 1'b0;
            valve_in    <= 1'b0;
            pump_out    <= 1'b0;
            motor_wash  <= 1'b0;
            motor_spin  <= 1'b0;
            door_lock   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= n_state;
            mode_q      <= n_mode;
            rinses_left <= n_rinses;
            washed      <= n_washed;
            presc       <= n_presc;
            secs_left   <= n_secs;
            paused      <= n_paused;
            valve_in    <= (n_state == S_FILL) && !n_paused;
            pump_out    <= ((n_state == S_DRAIN) || (n_state == S_SPIN)) && !n_paused;
            motor_wash  <= ((n_state == S_WASH) || (n_state == S_RINSE)) && !n_paused;
            motor_spin  <= (n_state == S_SPIN) && !n_paused;
            // in ERROR the door stays locked while water remains in the drum
            door_lock   <= n_running || ((n_state == S_ERROR) && !water_empty);
            done        <= (n_state == S_DONE);
            error       <= (n_state == S_ERROR);
        end
    end
endmodule

// File: tb/tb_ciclo_lavagem.sv
// tb/tb_ciclo_lavagem.sv - randomized self-checking bench for ciclo_lavagem
module tb_ciclo_lavagem;
    localparam int TPS = 4;
    localparam int WS  = 2;
    localparam int RS  = 1;
    localparam int SS  = 3;
    localparam int FT  = 5;

    logic       clock;
    logic       reset;
    logic [2:0] mode;
    logic       start, pause, door_closed, water_full, water_empty;
    logic       valve_in, pump_out, motor_wash, motor_spin, door_lock;
    logic [2:0] phase;
    logic [7:0] secs_left;
    logic       paused, done, error;
    logic [18:0] outs;

    int checks = 0;
    int failures = 0;

    int exp_ph[$];
    int exp_len[$];
    int got_ph[$];
    int got_act[$];
    int got_pz[$];

    int         bad_act, bad_secs, bad_pz;
    logic [6:0] act_got, act_exp;
    int         secs_got, secs_exp;
    int         pz_got_v, pz_exp_v;

    ciclo_lavagem #(
        .TICKS_PER_SEC(TPS), .WASH_S(WS), .RINSE_S(RS), .SPIN_S(SS), .FILL_TIMEOUT_S(FT)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .start(start), .pause(pause),
        .door_closed(door_closed), .water_full(water_full), .water_empty(water_empty),
        .valve_in(valve_in), .pump_out(pump_out), .motor_wash(motor_wash),
        .motor_spin(motor_spin), .door_lock(door_lock), .phase(phase),
        .secs_left(secs_left), .paused(paused), .done(done), .error(error)
    );

    assign outs = {phase, secs_left, valve_in, pump_out, motor_wash, motor_spin,
                   door_lock, paused, done, error};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    // Seconds each timed phase lasts for a program
    function automatic int dur_of(input int ph, input int m);
        case (ph)
            1, 3:    return FT;
            2:       return m * WS;
            4:       return RS;
            5:       return (m == 4) ? 2 * SS : SS;
            default: return 0;
        endcase
    endfunction

    // {valve, pump, wash, spin, lock, done, error} expected in a running phase
    function automatic logic [6:0] exp_act(input int ph, input bit pz);
        logic [6:0] v;
        v    = '0;
        v[2] = (ph >= 1 && ph <= 5);
        if (!pz) begin
            v[6] = (ph == 1);
            v[5] = (ph == 3 || ph == 5);
            v[4] = (ph == 2 || ph == 4);
            v[3] = (ph == 5);
        end
        return v;
    endfunction

    // Program-level model: list of phases and their active lengths in cycles
    task automatic build_model(input int m, input int fdly, input int ddly);
        int rin;
        exp_ph.delete();
        exp_len.delete();
        if (fdly + 1 > FT * TPS) begin
            exp_ph.push_back(1); exp_len.push_back(FT * TPS);
            exp_ph.push_back(7); exp_len.push_back(0);
            return;
        end
        exp_ph.push_back(1); exp_len.push_back(fdly + 1);
        exp_ph.push_back(2); exp_len.push_back(m * WS * TPS);
        exp_ph.push_back(3); exp_len.push_back(ddly + 1);
        rin = (m >= 3) ? 2 : 1;
        for (int r = 0; r < rin; r++) begin
            exp_ph.push_back(1); exp_len.push_back(fdly + 1);
            exp_ph.push_back(4); exp_len.push_back(RS * TPS);
            exp_ph.push_back(3); exp_len.push_back(ddly + 1);
        end
        exp_ph.push_back(5); exp_len.push_back(dur_of(5, m) * TPS);
        exp_ph.push_back(6); exp_len.push_back(0);
    endtask

    task automatic run_program(input int m, input int fdly, input int ddly,
                               input int pz_phase, input int pz_at, input int pz_hold,
                               input bit door_mode, input int stop_phase);
        int cur, cyc, act, pcnt, pz_state, budget, ph, k;
        bit exp_pz, exp_pz_next;
        logic [6:0] ea;
        got_ph.delete(); got_act.delete(); got_pz.delete();
        bad_act = 0; bad_secs = 0; bad_pz = 0;
        act_got = '0; act_exp = '0; secs_got = 0; secs_exp = 0; pz_got_v = 0; pz_exp_v = 0;
        @(negedge clock);
        mode = 3'(m); start = 1'b1; pause = 1'b0; door_closed = 1'b1;
        water_full = 1'b0; water_empty = 1'b0;
        @(negedge clock);
        start = 1'b0;
        cur = -1; cyc = 0; act = 0; pcnt = 0; pz_state = 0; budget = 2000; exp_pz = 1'b0;
        while (budget > 0) begin
            ph = int'(phase);
            if (ph != cur) begin
                got_ph.push_back(ph); got_act.push_back(0); got_pz.push_back(0);
                cur = ph; cyc = 0; act = 0; pcnt = 0;
            end
            if (ph == 0 || ph == 6 || ph == 7) break;
            if (ph == stop_phase && act >= 2) break;
            ea = exp_act(ph, exp_pz);
            if ({valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error} !== ea) begin
                if (bad_act == 0) begin
                    act_got = {valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error};
                    act_exp = ea;
                end
                bad_act++;
            end
            if (int'(secs_left) != dur_of(ph, m) - act / TPS) begin
                if (bad_secs == 0) begin
                    secs_got = int'(secs_left);
                    secs_exp = dur_of(ph, m) - act / TPS;
                end
                bad_secs++;
            end
            if (paused !== exp_pz) begin
                if (bad_pz == 0) begin
                    pz_got_v = int'(paused);
                    pz_exp_v = int'(exp_pz);
                end
                bad_pz++;
            end
            k = got_act.size() - 1;
            if (paused) got_pz[k] = got_pz[k] + 1;
            else        got_act[k] = got_act[k] + 1;
            exp_pz_next = exp_pz;
            pause       = 1'b0;
            mode        = 3'($urandom_range(0, 7));
            water_full  = (ph == 1) && (cyc >= fdly);
            water_empty = (ph == 3) && (cyc >= ddly);
            if (pz_state == 0 && ph == pz_phase && !paused && act == pz_at) begin
                if (door_mode) door_closed = 1'b0;
                else           pause = 1'b1;
                exp_pz_next = 1'b1;
                pz_state    = 1;
            end else if (pz_state == 1 && paused) begin
                pcnt++;
                if (door_mode && pcnt == 1) pause = 1'b1;
                if (door_mode && pcnt == 2) door_closed = 1'b1;
                if (pcnt == pz_hold) begin
                    pause       = 1'b1;
                    exp_pz_next = 1'b0;
                    pz_state    = 2;
                end
            end
            if (!paused) act++;
            cyc++;
            exp_pz = exp_pz_next;
            @(negedge clock);
            budget--;
        end
        pause = 1'b0; water_full = 1'b0; water_empty = 1'b0; door_closed = 1'b1;
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL run_budget got=exhausted expected=terminal phase");
        end
    endtask

    task automatic compare_sequence(input string name, input int pz_hold);
        int n, pz_seen;
        checks++;
        if (got_ph.size() != exp_ph.size()) begin
            failures++;
            $display("FAIL %s entries got=%0d expected=%0d", name, got_ph.size(), exp_ph.size());
        end
        n = (got_ph.size() < exp_ph.size()) ? got_ph.size() : exp_ph.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_ph[i] != exp_ph[i] || got_act[i] != exp_len[i]) begin
                failures++;
                $display("FAIL %s step%0d phase/cycles got=%0d/%0d expected=%0d/%0d",
                         name, i, got_ph[i], got_act[i], exp_ph[i], exp_len[i]);
            end
        end
        pz_seen = 0;
        foreach (got_pz[i]) pz_seen += got_pz[i];
        checks++;
        if (pz_seen != pz_hold) begin
            failures++;
            $display("FAIL %s paused_cycles got=%0d expected=%0d", name, pz_seen, pz_hold);
        end
        checks++;
        if (bad_act != 0) begin
            failures++;
            $display("FAIL %s actuators got=%b expected=%b bad_cycles=%0d", name, act_got, act_exp, bad_act);
        end
        checks++;
        if (bad_secs != 0) begin
            failures++;
            $display("FAIL %s secs_left got=%0d expected=%0d bad_cycles=%0d", name, secs_got, secs_exp, bad_secs);
        end
        checks++;
        if (bad_pz != 0) begin
            failures++;
            $display("FAIL %s paused_flag got=%0d expected=%0d bad_cycles=%0d", name, pz_got_v, pz_exp_v, bad_pz);
        end
    endtask

    task automatic finish_program(input string name);
        if (phase == 3'd6) begin
            checks++;
            if ({valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error} !== 7'b0000010) begin
                failures++;
                $display("FAIL %s done_outputs got=%b expected=%b", name,
                         {valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error}, 7'b0000010);
            end
            door_closed = 1'b0;
            @(negedge clock);
            checks++;
            if (phase !== 3'd0 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s door_open_idle got=%0d/%0d expected=0/0", name, phase, done);
            end
            door_closed = 1'b1;
        end else begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mode = 3'd1; door_closed = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (outs !== 19'd0) begin
            failures++;
            $display("FAIL reset_state got=%h expected=0", outs);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        checks++;
        if (outs !== 19'd0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h expected=0", outs);
        end
    endtask

    task automatic test_invalid_start();
        logic [2:0] modes [5];
        bit         doors [5];
        int         bad;
        modes = '{3'd0, 3'd6, 3'd5, 3'd7, 3'd2};
        doors = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            mode = modes[i]; door_closed = doors[i]; start = 1'b1; pause = 1'b1;
            bad = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                start = 1'b0; pause = 1'b0;
                if (outs !== 19'd0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL invalid_start%0d got=%h expected=0", i, outs);
            end
            door_closed = 1'b1;
        end
    endtask

    task automatic test_start_pause();
        @(negedge clock);
        mode = 3'd2; door_closed = 1'b1; start = 1'b1; pause = 1'b1;
        @(negedge clock);
        start = 1'b0; pause = 1'b0;
        checks++;
        if (phase !== 3'd1 || paused !== 1'b0 || valve_in !== 1'b1 || door_lock !== 1'b1 || secs_left !== 8'(FT)) begin
            failures++;
            $display("FAIL start_with_pause got=ph%0d/pz%0d/v%0d/s%0d expected=ph1/pz0/v1/s%0d",
                     phase, paused, valve_in, secs_left, FT);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        build_model(1, 3, 2);
        run_program(1, 3, 2, -1, 0, 0, 1'b0, -1);
        compare_sequence("nominal_mode1", 0);
        finish_program("nominal_mode1");
    endtask

    task automatic test_fill_timeout();
        int m;
        m = $urandom_range(1, 4);
        build_model(m, FT * TPS - 1, 3);
        run_program(m, FT * TPS - 1, 3, -1, 0, 0, 1'b0, -1);
        compare_sequence("fill_sensor_at_timeout", 0);
        finish_program("fill_sensor_at_timeout");
        build_model(m, 1000, 3);
        run_program(m, 1000, 3, -1, 0, 0, 1'b0, -1);
        compare_sequence("fill_timeout", 0);
        checks++;
        if ({phase, valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error} !== {3'd7, 7'b0000101}) begin
            failures++;
            $display("FAIL error_entry got=%b expected=%b",
                     {phase, valve_in, pump_out, motor_wash, motor_spin, door_lock, done, error}, {3'd7, 7'b0000101});
        end
        start = 1'b1; mode = 3'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (phase !== 3'd7 || door_lock !== 1'b1 || error !== 1'b1) begin
            failures++;
            $display("FAIL error_sticky got=ph%0d/lock%0d/err%0d expected=ph7/lock1/err1", phase, door_lock, error);
        end
        water_empty = 1'b1;
        @(negedge clock);
        checks++;
        if (phase !== 3'd7 || door_lock !== 1'b0 || error !== 1'b1) begin
            failures++;
            $display("FAIL error_unlock got=ph%0d/lock%0d/err%0d expected=ph7/lock0/err1", phase, door_lock, error);
        end
        water_empty = 1'b0;
        @(negedge clock);
        checks++;
        if (door_lock !== 1'b1) begin
            failures++;
            $display("FAIL error_relock got=%0d expected=1", door_lock);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (outs !== 19'd0) begin
            failures++;
            $display("FAIL error_reset got=%h expected=0", outs);
        end
    endtask

    task automatic test_pause_wash();
        build_model(2, 2, 1);
        run_program(2, 2, 1, 2, 5, 10, 1'b0, -1);
        compare_sequence("pause_wash", 10);
        finish_program("pause_wash");
    endtask

    task automatic test_door_spin();
        int m, hold, at;
        m    = $urandom_range(1, 4);
        hold = $urandom_range(3, 8);
        at   = $urandom_range(0, dur_of(5, m) * TPS - 2);
        build_model(m, 1, 2);
        run_program(m, 1, 2, 5, at, hold, 1'b1, -1);
        compare_sequence("door_open_spin", hold);
        finish_program("door_open_spin");
    endtask

    task automatic test_reset_mid_rinse();
        int m;
        m = $urandom_range(1, 4);
        run_program(m, 2, 2, -1, 0, 0, 1'b0, 4);
        checks++;
        if (phase !== 3'd4) begin
            failures++;
            $display("FAIL reach_rinse got=%0d expected=4", phase);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (outs !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid_rinse got=%h expected=0", outs);
        end
        build_model(4, 2, 3);
        run_program(4, 2, 3, -1, 0, 0, 1'b0, -1);
        compare_sequence("mode4_after_reset", 0);
        finish_program("mode4_after_reset");
    endtask

    task automatic test_random();
        int m, fdly, ddly, pzp, at, hold, len;
        bit dm, use_pz;
        for (int it = 0; it < 5; it++) begin
            m      = $urandom_range(1, 4);
            fdly   = $urandom_range(0, 8);
            ddly   = $urandom_range(0, 6);
            use_pz = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       pzp = 2;
                1:       pzp = 4;
                default: pzp = 5;
            endcase
            len  = dur_of(pzp, m) * TPS;
            at   = $urandom_range(0, len - 2);
            hold = use_pz ? $urandom_range(3, 8) : 0;
            dm   = 1'($urandom_range(0, 1));
            build_model(m, fdly, ddly);
            run_program(m, fdly, ddly, use_pz ? pzp : -1, at, hold, dm, -1);
            compare_sequence($sformatf("random%0d", it), hold);
            finish_program($sformatf("random%0d", it));
        end
    endtask

    initial begin
        reset = 1'b1; mode = 3'd0; start = 1'b0; pause = 1'b0;
        door_closed = 1'b1; water_full = 1'b0; water_empty = 1'b0;
        test_reset();
        test_invalid_start();
        test_start_pause();
        test_nominal();
        test_fill_timeout();
        test_pause_wash();
        test_door_spin();
        test_reset_mid_rinse();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
